// File: rtl/picosoc_mem_ctrl.sv
// On-chip RAM slave for the PicoSoC native memory bus: an address window, programmable
// wait states, registered mem_ready/mem_rdata and a busy flag over lane-strobed storage.
module picosoc_mem_ctrl #(
  parameter int          WORDS       = 256,
  parameter int          NUM_LANES   = 4,
  parameter int          LANE_WIDTH  = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            mem_valid,
  input  logic [31:0]                     mem_addr,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] mem_wdata,
  input  logic [NUM_LANES-1:0]            mem_wstrb,
  output logic                            mem_ready,
  output logic [NUM_LANES*LANE_WIDTH-1:0] mem_rdata,
  output logic                            sel,
  output logic                            busy
);

  localparam int          DW        = NUM_LANES * LANE_WIDTH;
  localparam int          IW        = $clog2(WORDS);
  localparam int          OW        = $clog2(NUM_LANES);
  localparam logic [31:0] WIN_BYTES = 32'(WORDS * NUM_LANES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t               state, state_nxt;
  logic [3:0]           wait_cnt, wait_cnt_nxt;
  logic                 latch_req;
  logic [31:0]          offset;
  logic [IW-1:0]        index, idx_q;
  logic [DW-1:0]        wdata_q;
  logic [NUM_LANES-1:0] wstrb_q;
  logic [DW-1:0]        mem [WORDS];

  // Unsigned offset makes addresses below BASE_ADDR wrap to huge values, so one compare bounds both ends.
  assign offset = mem_addr - BASE_ADDR;
  assign sel    = mem_valid && (offset < WIN_BYTES);
  assign index  = offset[OW +: IW];

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    latch_req    = 1'b0;
    case (state)
      S_IDLE: begin
        if (sel) begin
          latch_req    = 1'b1;
          wait_cnt_nxt = 4'(WAIT_STATES);
          state_nxt    = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        if (!mem_valid) begin
          state_nxt    = S_IDLE;
          wait_cnt_nxt = 4'd0;
        end else begin
          wait_cnt_nxt = wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      wait_cnt  <= 4'd0;
      busy      <= 1'b0;
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      busy      <= (state_nxt != S_IDLE);
      mem_ready <= (state == S_ACCESS);
      if (state == S_ACCESS) mem_rdata <= mem[idx_q];
      if (latch_req) begin
        idx_q   <= index;
        wdata_q <= mem_wdata;
        wstrb_q <= mem_wstrb;
      end
    end
  end

  // NOTE: the array has no reset; contents survive resetn, and an aborted access never reaches ACCESS.
  always_ff @(posedge clk) begin
    if (state == S_ACCESS) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (wstrb_q[l]) mem[idx_q][l*LANE_WIDTH +: LANE_WIDTH] <= wdata_q[l*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_picosoc_mem_ctrl.sv
// Self-checking bench: two instances (0 and 3 wait states) against a transaction-level model
// that tracks each access by its age in cycles and holds the memory image as a plain array.
module tb_picosoc_mem_ctrl;

  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam logic [31:0] WIN  = 32'd1024;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  wstrb [2];
  logic        ready [2];
  logic [31:0] rdata [2];
  logic        sel   [2];
  logic        busy  [2];

  int vectors     = 0;
  int miscompares = 0;
  bit cmp_en      = 1'b0;

  always #5 clk = ~clk;

  picosoc_mem_ctrl #(.WORDS(256), .NUM_LANES(4), .LANE_WIDTH(8), .BASE_ADDR(BASE), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .resetn(resetn), .mem_valid(valid[0]), .mem_addr(addr[0]), .mem_wdata(wdata[0]),
    .mem_wstrb(wstrb[0]), .mem_ready(ready[0]), .mem_rdata(rdata[0]), .sel(sel[0]), .busy(busy[0]));

  picosoc_mem_ctrl #(.WORDS(256), .NUM_LANES(4), .LANE_WIDTH(8), .BASE_ADDR(BASE), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .resetn(resetn), .mem_valid(valid[1]), .mem_addr(addr[1]), .mem_wdata(wdata[1]),
    .mem_wstrb(wstrb[1]), .mem_ready(ready[1]), .mem_rdata(rdata[1]), .sel(sel[1]), .busy(busy[1]));

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic bit in_win(input logic [31:0] a);
    return (a - BASE) < WIN;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: age = edges since acceptance (-1 when idle); the access commits at age WS+1.
  int          m_age      [2];
  int          m_idx      [2];
  logic [31:0] m_wd       [2];
  logic [3:0]  m_st       [2];
  logic [31:0] m_rdata    [2];
  bit          m_rd_known [2];
  logic [31:0] m_mem      [2][256];
  bit          m_known    [2][256];

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int d = 0; d < 2; d++) begin
        m_age[d] = -1; m_rdata[d] = '0; m_rd_known[d] = 1'b1;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (m_age[d] < 0) begin
          if (valid[d] && in_win(addr[d])) begin
            m_age[d] = 0;
            m_idx[d] = int'((addr[d] - BASE) >> 2);
            m_wd[d]  = wdata[d];
            m_st[d]  = wstrb[d];
          end
        end else begin
          m_age[d]++;
          if (m_age[d] <= ws_of(d) && !valid[d]) m_age[d] = -1;
          else if (m_age[d] == ws_of(d) + 1) begin
            m_rdata[d]    = m_mem[d][m_idx[d]];
            m_rd_known[d] = m_known[d][m_idx[d]];
            for (int l = 0; l < 4; l++)
              if (m_st[d][l]) m_mem[d][m_idx[d]][8*l +: 8] = m_wd[d][8*l +: 8];
            if (m_st[d] == 4'hF) m_known[d][m_idx[d]] = 1'b1;
          end else if (m_age[d] > ws_of(d) + 1) m_age[d] = -1;
        end
      end
    end
  end

  // Compare every cycle; inputs change only at negedge+1, so this sees settled values.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("sel[%0d]", d),   32'(sel[d]),   32'(valid[d] && in_win(addr[d])));
        check($sformatf("ready[%0d]", d), 32'(ready[d]), 32'(m_age[d] == ws_of(d) + 1));
        check($sformatf("busy[%0d]", d),  32'(busy[d]),  32'(m_age[d] >= 0));
        if (m_rd_known[d]) check($sformatf("rdata[%0d]", d), rdata[d], m_rdata[d]);
      end
    end
  end

  // One bus request; lat = negedges from the request cycle to the ready cycle, -1 if none.
  task automatic do_req(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                        input int drop_at, input bit scramble, output int lat, output logic [31:0] rd);
    lat = -1;
    rd  = 'x;
    @(negedge clk); #1;
    valid[d] = 1'b1; addr[d] = a; wdata[d] = wd; wstrb[d] = st;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (ready[d]) begin
        lat = n; rd = rdata[d];
        #1 valid[d] = 1'b0;
        break;
      end
      #1;
      if (n == drop_at) begin valid[d] = 1'b0; break; end
      if (scramble && n == 1) begin addr[d] = $urandom; wdata[d] = $urandom; wstrb[d] = 4'($urandom); end
    end
    if (valid[d]) begin
      vectors++; miscompares++;
      $display("FAIL timeout[%0d]: no mem_ready within 40 cycles for addr %h", d, a);
      valid[d] = 1'b0;
    end
    repeat ((drop_at > 0) ? 8 : 1) @(negedge clk);
  endtask

  task automatic probe_oow(input int d, input logic [31:0] a);
    @(negedge clk); #1;
    valid[d] = 1'b1; addr[d] = a; wdata[d] = 32'h0BAD_0BAD; wstrb[d] = 4'hF;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      check("oow_sel", 32'(sel[d]), 32'd0);
      check("oow_ready", 32'(ready[d]), 32'd0);
      check("oow_busy", 32'(busy[d]), 32'd0);
    end
    #1 valid[d] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    for (int d = 0; d < 2; d++) begin
      valid[d] = 1'b0; addr[d] = '0; wdata[d] = '0; wstrb[d] = '0;
    end
    resetn = 1'b1;
    #3 resetn = 1'b0;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    for (int d = 0; d < 2; d++) begin
      check("reset_ready", 32'(ready[d]), 32'd0);
      check("reset_rdata", rdata[d], 32'd0);
      check("reset_busy", 32'(busy[d]), 32'd0);
    end
    #2 resetn = 1'b1;

    // Zero wait states: latency, read-back, partial strobe, read-first.
    do_req(0, BASE + 4, 32'hDEAD_BEEF, 4'hF, 0, 0, lat, rd);
    check("ws0_write_lat", 32'(lat), 32'd2);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("ws0_single_pulse", 32'(ready[0]), 32'd0);
    end
    do_req(0, BASE + 4, 32'h0, 4'h0, 0, 0, lat, rd);
    check("ws0_read_lat", 32'(lat), 32'd2);
    check("readback", rd, 32'hDEAD_BEEF);
    do_req(0, BASE + 4, 32'h0055_0000, 4'b0100, 0, 0, lat, rd);
    do_req(0, BASE + 7, 32'h0, 4'h0, 0, 0, lat, rd);
    check("partial_strobe", rd, 32'hDE55_BEEF);
    do_req(0, BASE + 8, 32'hDEAD_BEEF, 4'hF, 0, 0, lat, rd);
    do_req(0, BASE + 8, 32'h1234_5678, 4'hF, 0, 0, lat, rd);
    check("read_first", rd, 32'hDEAD_BEEF);
    do_req(0, BASE + 8, 32'h0, 4'h0, 0, 0, lat, rd);
    check("after_write", rd, 32'h1234_5678);

    // Window bounds: neighbours outside stay silent and word 0 is untouched.
    do_req(0, BASE, 32'h600D_F00D, 4'hF, 0, 0, lat, rd);
    probe_oow(0, BASE - 4);
    probe_oow(0, BASE + WIN);
    do_req(0, BASE, 32'h0, 4'h0, 0, 0, lat, rd);
    check("word0_untouched", rd, 32'h600D_F00D);
    do_req(0, BASE + WIN - 4, 32'hA5A5_5A5A, 4'hF, 0, 0, lat, rd);
    do_req(0, BASE + WIN - 4, 32'h0, 4'h0, 0, 0, lat, rd);
    check("last_word", rd, 32'hA5A5_5A5A);

    // Three wait states: latency, abandoned request, reset during WAIT.
    do_req(1, BASE + 16, 32'hCAFE_F00D, 4'hF, 0, 0, lat, rd);
    check("ws3_write_lat", 32'(lat), 32'd5);
    do_req(1, BASE + 16, 32'h1111_1111, 4'hF, 1, 0, lat, rd);
    check("drop_no_ready", 32'(lat), 32'hFFFF_FFFF);
    do_req(1, BASE + 16, 32'h0, 4'h0, 0, 0, lat, rd);
    check("ws3_read_lat", 32'(lat), 32'd5);
    check("drop_unchanged", rd, 32'hCAFE_F00D);

    @(negedge clk); #1;
    valid[1] = 1'b1; addr[1] = BASE + 16; wdata[1] = 32'h2222_2222; wstrb[1] = 4'hF;
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("midreset_busy", 32'(busy[1]), 32'd0);
    check("midreset_ready", 32'(ready[1]), 32'd0);
    check("midreset_rdata", rdata[1], 32'd0);
    valid[1] = 1'b0;
    @(negedge clk);
    #2 resetn = 1'b1;
    do_req(1, BASE + 16, 32'h0, 4'h0, 0, 0, lat, rd);
    check("midreset_word", rd, 32'hCAFE_F00D);
    do_req(0, BASE + 8, 32'h0, 4'h0, 0, 0, lat, rd);
    check("retained_over_reset", rd, 32'h1234_5678);

    // Randomized traffic; rdata, sel, busy and ready are checked by the compare process.
    for (int d = 0; d < 2; d++) begin
      for (int t = 0; t < 150; t++) begin
        logic [31:0] a;
        logic [3:0]  st;
        int          drop;
        int          word;
        if ($urandom_range(0, 99) < 8) begin
          a = ($urandom_range(0, 1) == 0) ? BASE - 32'(4 * $urandom_range(1, 16))
                                          : BASE + WIN + 32'(4 * $urandom_range(0, 16));
          do_req(d, a, $urandom, 4'hF, 6, 0, lat, rd);
          check("rand_oow_lat", 32'(lat), 32'hFFFF_FFFF);
        end else begin
          word = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15));
          a    = BASE + 32'(word * 4) + 32'($urandom_range(0, 3));
          st   = ($urandom_range(0, 9) < 4) ? 4'h0 : 4'($urandom_range(1, 15));
          drop = (d == 1 && $urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0;
          do_req(d, a, $urandom, st, drop, $urandom_range(0, 3) == 0, lat, rd);
          check("rand_lat", 32'(lat), (drop > 0) ? 32'hFFFF_FFFF : 32'(ws_of(d) + 2));
        end
      end
    end

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/picosoc_mem_ctrl.md
Name: picosoc_mem_ctrl

Overview:
- Parametrised on-chip RAM slave for the PicoSoC native memory bus (mem_valid/mem_ready handshake).
- Built from NUM_LANES independent lanes, each LANE_WIDTH bits wide with its own write strobe.
- Adds over the plain byte-banked RAM: an address window, programmable wait states, a registered ready handshake and a busy flag.
- Sits between the PicoRV32 bus and the interconnect; accesses outside its window are ignored so another slave can answer them.

Parameters:
- WORDS, 256: array depth in words; power of two, at least 2.
- NUM_LANES, 4: strobe lanes per word; power of two, 1..8.
- LANE_WIDTH, 8: bits per lane; the data width is DW = NUM_LANES*LANE_WIDTH.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be aligned to WORDS*NUM_LANES.
- WAIT_STATES, 0: extra stall cycles per access, 0..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- mem_valid  in  1  request valid; held until mem_ready.
- mem_addr  in  32  byte address.
- mem_wdata  in  DW  write data.
- mem_wstrb  in  NUM_LANES  per-lane write strobe; all zero means a read.
- mem_ready  out  1  registered; one-cycle completion pulse.
- mem_rdata  out  DW  registered read data.
- sel  out  1  combinational: mem_valid && address inside the window.
- busy  out  1  registered; high whenever the state is not IDLE.

Behaviour:
- Address window and indexing:
  - Window is [BASE_ADDR, BASE_ADDR + WORDS*NUM_LANES).
  - Word index = (mem_addr - BASE_ADDR) >> log2(NUM_LANES), truncated to log2(WORDS) bits.
  - Low offset bits are ignored.
- Reset (asynchronous on resetn low):
  - State goes to IDLE; mem_ready=0, mem_rdata=0, busy=0, wait counter=0.
  - Array contents are not cleared and are retained across reset.
  - Reset mid-access aborts it. Any write not yet committed in ACCESS is lost; a write already committed stays.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - On an edge with sel=1, latch index, wdata and wstrb.
  - Load the counter with WAIT_STATES.
  - Go to WAIT if WAIT_STATES>0, else to ACCESS.
- WAIT:
  - Counter decrements each edge; move to ACCESS on the edge where the counter is 1.
  - If mem_valid is low on an edge, return to IDLE. No array write happens and no mem_ready is issued.
- ACCESS, one edge:
  - Every lane registers the array word into mem_rdata.
  - Each lane with its wstrb bit set writes its wdata slice.
  - Read-first: for a write access, mem_rdata shows the old contents.
  - mem_valid is not checked; the access commits unconditionally.
  - Next state is RESP.
- RESP:
  - mem_ready=1 for exactly this one cycle; next state IDLE.
  - A request still valid in the cycle after RESP is treated as a new request.
- Latency: mem_ready rises WAIT_STATES+2 cycles after the sampling edge in IDLE. Throughput is one access per WAIT_STATES+3 cycles.
- mem_rdata holds its value until the next ACCESS edge.
- Requests outside the window:
  - Never leave IDLE and never drive mem_ready.
  - sel stays 0 and the array is untouched.
- Partial strobes: unselected lanes keep their contents; all lanes are read back.
- Index wrap: the top word is reachable; BASE_ADDR + WORDS*NUM_LANES is outside the window (sel=0).
- Address and data changes while busy are ignored; the latched copy is used.

Test Plan:
- Reset, then write: resetn low, then high; check mem_ready=0, mem_rdata=0, busy=0. Write 32'hDEADBEEF to BASE_ADDR+4 with wstrb=4'hF at WAIT_STATES=0; mem_ready must pulse exactly once, 2 cycles after the request edge.
- Read-back: read BASE_ADDR+4; mem_rdata=32'hDEADBEEF in the mem_ready cycle. Write 8'h55 with wstrb=4'b0100; a following read returns 32'hDE55BEEF.
- Read-first: write 32'h12345678 to a word holding 32'hDEADBEEF; mem_rdata in that ready cycle is 32'hDEADBEEF.
- Wait states: with WAIT_STATES=3, mem_ready rises 5 cycles after the request edge. Dropping mem_valid after 1 WAIT cycle gives no mem_ready and leaves the word unchanged.
- Window bounds: requests at BASE_ADDR-4 and BASE_ADDR+WORDS*4 give sel=0, no mem_ready and busy=0. The last word, BASE_ADDR+WORDS*4-4, writes and reads correctly.
- Reset mid-access: assert resetn low in the WAIT state during a write; state returns to IDLE, the word is unchanged and data written earlier is retained.
